uart_rxr: RTL and testbench



---
 rtl/uart_rxr.sv | 104 ++++++++++
 tb/tb_uart_rxr.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxr.sv
// 8N1 UART receiver: synchronises the RX line, samples each bit at mid-period,
// emits good bytes with a one-cycle valid strobe and flags bad stop bits.
module uart_rxr #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxline,
  output logic [7:0] o_byte,
  output logic       o_data_valid,
  output logic       o_framing_error,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m            <= 1'b1;
      rx_s            <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shift           <= '0;
      o_byte          <= '0;
      o_data_valid    <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      rx_m            <= i_rxline;
      rx_s            <= rx_m;
      o_data_valid    <= 1'b0;
      o_framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        // A start bit that is no longer low at its midpoint is a glitch
        START: begin
          if (cnt != HALF) begin
            cnt <= cnt + 1'b1;
          end else if (!rx_s) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            shift[idx] <= rx_s;
            cnt        <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 1'b1;
          end
        end
        // Returning to IDLE at mid-stop-bit lets a gapless next frame be caught
        STOP: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (rx_s) begin
              o_byte       <= shift;
              o_data_valid <= 1'b1;
              state        <= IDLE;
            end else begin
              o_framing_error <= 1'b1;
              state           <= BRK;
            end
          end
        end
        // Hold here while the line is low so a break is not read as 0x00 bytes
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rxr.sv
// Bench for uart_rxr: frames are driven serially and received bytes, strobe
// timing and flags are compared against the frames the bench itself sent.
`timescale 1ns/1ps
module tb_uart_rxr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, rx2;
  logic [7:0] byte_a, byte_b;
  logic       dv_a, fe_a, busy_a, dv_b, fe_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rxr #(.CLKS_PER_BIT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxline(rx),
    .o_byte(byte_a), .o_data_valid(dv_a), .o_framing_error(fe_a), .o_busy(busy_a)
  );

  uart_rxr dut434 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxline(rx2),
    .o_byte(byte_b), .o_data_valid(dv_b), .o_framing_error(fe_b), .o_busy(busy_b)
  );

  // Monitors: log strobes with the cycle they were seen in
  int         dv_cyc[$];
  logic [7:0] dv_byte[$];
  int         fe_cyc[$];
  logic [7:0] b_bytes[$];
  int         fe_b_cnt = 0;
  int         both_viol = 0;
  int         dbl_viol = 0;
  logic       prev_p = 1'b0;

  always @(negedge clk) begin
    if (dv_a) begin
      dv_cyc.push_back(cyc);
      dv_byte.push_back(byte_a);
    end
    if (fe_a) fe_cyc.push_back(cyc);
    if (dv_a && fe_a) both_viol <= both_viol + 1;
    if ((dv_a || fe_a) && prev_p) dbl_viol <= dbl_viol + 1;
    prev_p <= dv_a || fe_a;
    if (dv_b) b_bytes.push_back(byte_b);
    if (fe_b) fe_b_cnt <= fe_b_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Frame at 8 clocks/bit, starting on the current negedge; t0 = cycle of the falling edge
  task automatic send8(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_logs();
    dv_cyc.delete();
    dv_byte.delete();
    fe_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_a, dv_a, fe_a, busy_a} !== 11'h0) begin
      errors++;
      $display("FAIL reset_a got %0h want 0", {byte_a, dv_a, fe_a, busy_a});
    end
    checks++;
    if ({byte_b, dv_b, fe_b, busy_b} !== 11'h0) begin
      errors++;
      $display("FAIL reset_b got %0h want 0", {byte_b, dv_b, fe_b, busy_b});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || dv_cyc.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset busy %0b pulses %0d want 0 0", busy_a, dv_cyc.size());
    end
  endtask

  task automatic test_good_byte();
    int t0;
    clear_logs();
    send8(8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != 1 || fe_cyc.size() != 0) begin
      errors++;
      $display("FAIL good_count dv %0d fe %0d want 1 0", dv_cyc.size(), fe_cyc.size());
    end else begin
      checks++;
      if (dv_byte[0] !== 8'hA5 || dv_cyc[0] != t0 + 79) begin
        errors++;
        $display("FAIL good_byte got %0h@%0d want a5@%0d", dv_byte[0], dv_cyc[0], t0 + 79);
      end
    end
    checks++;
    if (byte_a !== 8'hA5 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL good_hold byte %0h busy %0b want a5 0", byte_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    int         t[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h31;
    clear_logs();
    for (int i = 0; i < 3; i++) send8(exp_b[i], 1'b1, t[i]);
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", dv_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dv_byte[i] !== exp_b[i] || dv_cyc[i] != t[i] + 79) begin
          errors++;
          $display("FAIL b2b_%0d got %0h@%0d want %0h@%0d", i, dv_byte[i], dv_cyc[i], exp_b[i], t[i] + 79);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_b[$];
    int         exp_c[$];
    logic [7:0] b;
    int         t0;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send8(b, 1'b1, t0);
      exp_b.push_back(b);
      exp_c.push_back(t0 + 79);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != exp_b.size() || fe_cyc.size() != 0) begin
      errors++;
      $display("FAIL rand_count dv %0d fe %0d want %0d 0", dv_cyc.size(), fe_cyc.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        checks++;
        if (dv_byte[i] !== exp_b[i] || dv_cyc[i] != exp_c[i]) begin
          errors++;
          $display("FAIL rand_%0d got %0h@%0d want %0h@%0d", i, dv_byte[i], dv_cyc[i], exp_b[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int t0;
    clear_logs();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || dv_cyc.size() != 0 || fe_cyc.size() != 0) begin
      errors++;
      $display("FAIL glitch busy %0b dv %0d fe %0d want 0 0 0", busy_a, dv_cyc.size(), fe_cyc.size());
    end
    send8(8'h5A, 1'b1, t0);
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != 1 || byte_a !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_next count %0d byte %0h want 1 5a", dv_cyc.size(), byte_a);
    end
  endtask

  task automatic test_framing();
    logic [7:0] prev;
    int         t0;
    prev = byte_a;
    clear_logs();
    send8(8'h3C, 1'b0, t0);
    repeat (40) @(negedge clk);
    checks++;
    if (fe_cyc.size() != 1 || dv_cyc.size() != 0) begin
      errors++;
      $display("FAIL fe_count fe %0d dv %0d want 1 0", fe_cyc.size(), dv_cyc.size());
    end else begin
      checks++;
      if (fe_cyc[0] != t0 + 79) begin
        errors++;
        $display("FAIL fe_time got %0d want %0d", fe_cyc[0], t0 + 79);
      end
    end
    checks++;
    if (byte_a !== prev || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL fe_hold byte %0h busy %0b want %0h 1", byte_a, busy_a, prev);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL break_exit busy %0b want 0", busy_a);
    end
    clear_logs();
    send8(8'h42, 1'b1, t0);
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != 1 || byte_a !== 8'h42 || fe_cyc.size() != 0) begin
      errors++;
      $display("FAIL fe_next count %0d byte %0h fe %0d want 1 42 0", dv_cyc.size(), byte_a, fe_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int         t0;
    b = 8'($urandom);
    clear_logs();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = b[4];
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_a, dv_a, fe_a, busy_a} !== 11'h0) begin
      errors++;
      $display("FAIL async_reset got %0h want 0", {byte_a, dv_a, fe_a, busy_a});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    clear_logs();
    send8(8'h81, 1'b1, t0);
    repeat (4) @(negedge clk);
    checks++;
    if (dv_cyc.size() != 1 || byte_a !== 8'h81 || dv_cyc[0] != t0 + 79) begin
      errors++;
      $display("FAIL reset_next count %0d byte %0h want 1 81", dv_cyc.size(), byte_a);
    end
  endtask

  // Default 434 clocks/bit; bit periods of 4470 ns and 4210 ns are +/-3% of 4340 ns
  task automatic send_skew(input logic [7:0] b, input int bit_ns);
    rx2 = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      #(bit_ns);
    end
    rx2 = 1'b1;
    #(bit_ns);
  endtask

  task automatic test_default_param();
    logic [7:0] r;
    r = 8'($urandom);
    b_bytes.delete();
    send_skew(8'h55, 4470);
    send_skew(8'h55, 4210);
    send_skew(r, 4470);
    repeat (600) @(negedge clk);
    checks++;
    if (b_bytes.size() != 3 || fe_b_cnt != 0) begin
      errors++;
      $display("FAIL skew_count got %0d fe %0d want 3 0", b_bytes.size(), fe_b_cnt);
    end else begin
      checks++;
      if (b_bytes[0] !== 8'h55 || b_bytes[1] !== 8'h55 || b_bytes[2] !== r) begin
        errors++;
        $display("FAIL skew_bytes got %0h %0h %0h want 55 55 %0h", b_bytes[0], b_bytes[1], b_bytes[2], r);
      end
    end
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL skew_busy got %0b want 0", busy_b);
    end
  endtask

  task automatic test_flags();
    checks++;
    if (both_viol != 0 || dbl_viol != 0) begin
      errors++;
      $display("FAIL strobe_rules both %0d consecutive %0d want 0 0", both_viol, dbl_viol);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_back_to_back();
    test_random();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_default_param();
    test_flags();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
